rf_regfile_trace: RTL

//  MIPS 32x32 general register file: two async read ports, one sync write port, r0 hardwired to zero.

---
 rtl/rf_regfile_trace_pkg.sv | 17 +
 rtl/rf_regfile_trace_if.sv | 38 +++
 rtl/rf_trace_fifo.sv | 64 ++++++
 rtl/rf_regfile_trace.sv | 101 ++++++++++
 4 files changed

// File: rtl/rf_regfile_trace_pkg.sv
// Shared constants and helpers for the MIPS register file with write-trace FIFO.
// Imported by the interface, the trace FIFO and the top level.
package rf_regfile_trace_pkg;

  localparam int RF_DW        = 32;
  localparam int RF_AW        = 5;
  localparam int RF_ZERO_ADDR = 0;
  localparam int RF_TRC_DEPTH = 8;
  localparam int RF_SEQ_W     = 8;
  localparam int RF_DROP_W    = 16;

  // Saturating increment for the dropped-entry counter.
  function automatic logic [RF_DROP_W-1:0] sat_inc(input logic [RF_DROP_W-1:0] v);
    return (v == '1) ? v : v + RF_DROP_W'(1);
  endfunction

endpackage

// File: rtl/rf_regfile_trace_if.sv
// Register-file bus: WB write side, ID read side and the trace drain port.
// The master modport is the pipeline/monitor side, the slave modport is the register file.
interface rf_regfile_trace_if
  import rf_regfile_trace_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int SEQ_W = RF_SEQ_W
) ();

  logic [AW-1:0]        rf_in_ra1;
  logic [AW-1:0]        rf_in_ra2;
  logic                 rf_in_wre;
  logic [AW-1:0]        rf_in_wa;
  logic [DW-1:0]        rf_in_wd;
  logic [DW-1:0]        rf_out_rd1;
  logic [DW-1:0]        rf_out_rd2;
  logic                 trc_valid;
  logic                 trc_ready;
  logic [AW-1:0]        trc_wa;
  logic [DW-1:0]        trc_wd;
  logic [SEQ_W-1:0]     trc_seq;
  logic                 trc_ovf;
  logic [RF_DROP_W-1:0] trc_drop_cnt;

  modport master (
    output rf_in_ra1, rf_in_ra2, rf_in_wre, rf_in_wa, rf_in_wd, trc_ready,
    input  rf_out_rd1, rf_out_rd2, trc_valid, trc_wa, trc_wd, trc_seq,
           trc_ovf, trc_drop_cnt
  );

  modport slave (
    input  rf_in_ra1, rf_in_ra2, rf_in_wre, rf_in_wa, rf_in_wd, trc_ready,
    output rf_out_rd1, rf_out_rd2, trc_valid, trc_wa, trc_wd, trc_seq,
           trc_ovf, trc_drop_cnt
  );

endinterface

// File: rtl/rf_trace_fifo.sv
// Synchronous FIFO for register-write trace entries; no fall-through, head is registered storage.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rf_trace_fifo
  import rf_regfile_trace_pkg::*;
#(
  parameter int W     = RF_AW + RF_DW + RF_SEQ_W,
  parameter int DEPTH = RF_TRC_DEPTH
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int           IW      = $clog2(DEPTH);
  localparam logic [IW:0]  PTR_ONE = (IW + 1)'(1);

  logic [IW:0]  wptr_q, wptr_d;
  logic [IW:0]  rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[IW] != rptr_q[IW]) && (wptr_q[IW-1:0] == rptr_q[IW-1:0]);
  assign dout  = mem_q[rptr_q[IW-1:0]];

  // NOTE: every variable in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q[IW-1:0]] = din;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_regfile_trace.sv
// MIPS 32x32 register file: two bypassed async read ports, one sync write port, r0 = 0.
// Every architectural write is also logged with a sequence number into a drainable trace FIFO.
module rf_regfile_trace
  import rf_regfile_trace_pkg::*;
#(
  parameter int DW        = RF_DW,
  parameter int AW        = RF_AW,
  parameter int TRC_DEPTH = RF_TRC_DEPTH,
  parameter int SEQ_W     = RF_SEQ_W
) (
  input  logic              clk,
  input  logic              rst_l,
  rf_regfile_trace_if.slave bus
);

  localparam int               NREG    = 2 ** AW;
  localparam int               TW      = AW + DW + SEQ_W;
  localparam logic [AW-1:0]    ZERO_A  = AW'(RF_ZERO_ADDR);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  logic [DW-1:0]        regs_q [NREG];
  logic [DW-1:0]        regs_d [NREG];
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 ovf_q, ovf_d;
  logic [RF_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic          log_ev;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [TW-1:0] fifo_din, fifo_dout;

  // Read ports: r0 is hard zero, a same-cycle write to the read address wins over the array.
  always_comb begin
    bus.rf_out_rd1 = '0;
    bus.rf_out_rd2 = '0;
    if (rst_l) begin
      if (bus.rf_in_ra1 != ZERO_A) begin
        bus.rf_out_rd1 = (bus.rf_in_wre && (bus.rf_in_wa == bus.rf_in_ra1))
                         ? bus.rf_in_wd : regs_q[bus.rf_in_ra1];
      end
      if (bus.rf_in_ra2 != ZERO_A) begin
        bus.rf_out_rd2 = (bus.rf_in_wre && (bus.rf_in_wa == bus.rf_in_ra2))
                         ? bus.rf_in_wd : regs_q[bus.rf_in_ra2];
      end
    end
  end

  always_comb begin
    log_ev     = bus.rf_in_wre && (bus.rf_in_wa != ZERO_A);
    fifo_pop   = !fifo_empty && bus.trc_ready;
    fifo_push  = log_ev && (!fifo_full || fifo_pop);
    drop       = log_ev && !fifo_push;
    fifo_din   = {bus.rf_in_wa, bus.rf_in_wd, seq_q};

    regs_d     = regs_q;
    seq_d      = seq_q;
    ovf_d      = ovf_q || drop;
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    if (log_ev) begin
      regs_d[bus.rf_in_wa] = bus.rf_in_wd;
      // Dropped writes still consume a sequence number so the monitor sees the gap.
      seq_d                = seq_q + SEQ_ONE;
    end
  end

  // NOTE: the architectural registers must read zero out of reset, so the array is reset here.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  rf_trace_fifo #(
    .W     (TW),
    .DEPTH (TRC_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (fifo_push),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  assign bus.trc_valid                       = !fifo_empty;
  assign {bus.trc_wa, bus.trc_wd, bus.trc_seq} = fifo_dout;
  assign bus.trc_ovf                         = ovf_q;
  assign bus.trc_drop_cnt                    = drop_cnt_q;

endmodule
